jtpopeye_dma_sched: RTL and testbench

JTPOPEYE_DMA_SCHED -- requirements
Module: jtpopeye_dma_sched

---
 rtl/jtpopeye_dma_sched.sv | 169 ++++++++++++++++
 tb/tb_jtpopeye_dma_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma_sched.sv
// ---------------------------------------------------------------------------
// jtpopeye_dma_sched
//
// Once per frame, copies LEN bytes from main RAM to object RAM while the CPU
// is held off the bus. A VB rising edge (sampled on cen) with dma_en=1 starts
// the sequence IDLE -> REQ -> XFER -> REL -> IDLE.
//
// Parameters
//   AW   address width of the source and object RAMs
//   LEN  bytes per frame, 1 .. 2**AW
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cen           clock enable; every state change waits for cen=1
//   VB            vertical blank
//   dma_en        transfer enable, only looked at in IDLE
//   busrq_n       bus request to the CPU (low in REQ and XFER)
//   busak_n       bus acknowledge from the CPU
//   src_addr      main-RAM read address
//   src_data      main-RAM read data, one cen behind src_addr
//   dst_addr      object-RAM write address
//   dst_data      object-RAM write data
//   dst_we        object-RAM write strobe, one cen per byte
//   busy          high whenever the FSM is not in IDLE
//   done          one-cen pulse when the transfer completes
//   err           sticky bus-acknowledge timeout flag
//                 (JTPOPEYE_DMA_TIMEOUT_EN builds only)
//
// Build option
//   JTPOPEYE_DMA_TIMEOUT_EN: give up the request after 64 cens without an
//   acknowledge, raise err and go back to IDLE without a done pulse.
// ---------------------------------------------------------------------------
module jtpopeye_dma_sched #(
   parameter int AW  = 10,
   parameter int LEN = 384
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          VB,
   input  logic          dma_en,
   output logic          busrq_n,
   input  logic          busak_n,
   output logic [AW-1:0] src_addr,
   input  logic [7:0]    src_data,
   output logic [AW-1:0] dst_addr,
   output logic [7:0]    dst_data,
   output logic          dst_we,
   output logic          busy,
   output logic          done
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   ,
   output logic          err
`endif
);

   // The counter is one bit wider than the address so k can reach LEN=2**AW.
   localparam logic [AW:0]   LEN_K = LEN[AW:0];
   localparam logic [AW:0]   ONE_K = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      REL  = 2'd3
   } state_t;

   state_t      state, nxt;
   logic [AW:0] k;          // byte counter
   logic        rd_vld;     // a read was issued on the previous cen
   logic [7:0]  data_buf;   // holds a read result across a bus pause
   logic        vb_last;    // VB at the previous cen
   logic        act;        // a cen on which the bus is ours
   logic        vb_rise;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   logic [5:0]  to_cnt;
   logic        to_hit;
   assign to_hit = cen && busak_n && (to_cnt == 6'd63);
`endif

   assign act     = cen && !busak_n;
   assign vb_rise = cen && VB && !vb_last;

   // ---------------------------------------------------------------------
   // State register and datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         rd_vld   <= 1'b0;
         data_buf <= 8'd0;
         vb_last  <= 1'b1;   // VB already high at reset release is not an edge
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
         to_cnt   <= 6'd0;
         err      <= 1'b0;
`endif
      end else begin
         state <= nxt;

         if (cen) begin
            vb_last <= VB;
            // src_data is only valid for the cen right after a read. If the
            // bus pauses in between, keep that byte for the delayed write.
            if (rd_vld) data_buf <= src_data;
            rd_vld <= (state == XFER) && !busak_n && (k < LEN_K);
         end

         if (state == XFER) begin
            if (act) k <= k + ONE_K;
         end else begin
            k <= '0;
         end

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
         if (state == REQ) begin
            if (cen) to_cnt <= to_cnt + 6'd1;
            if (to_hit) err <= 1'b1;
         end else begin
            to_cnt <= 6'd0;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      nxt      = state;
      busrq_n  = 1'b1;
      busy     = 1'b1;
      done     = 1'b0;
      dst_we   = 1'b0;
      src_addr = k[AW-1:0];
      dst_addr = k[AW-1:0] - ONE_A;
      // The write at k uses the read issued at k-1: straight from the RAM
      // when it arrived on this cen, otherwise from the pause buffer.
      dst_data = rd_vld ? src_data : data_buf;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (vb_rise && dma_en) nxt = REQ;
         end
         REQ: begin
            busrq_n = 1'b0;
            if (act) nxt = XFER;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            else if (to_hit) nxt = IDLE;
`endif
         end
         XFER: begin
            busrq_n = 1'b0;
            // k=0 only issues the first read; k=LEN only writes the last byte
            dst_we  = act && (k != '0) && !rst;
            if (act && (k == LEN_K)) nxt = REL;
         end
         REL: begin
            done = cen && !rst;
            if (cen) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_jtpopeye_dma_sched.sv
// ---------------------------------------------------------------------------
// Bench for jtpopeye_dma_sched. The stimulus thread pushes the expected
// object-RAM writes and done pulses into queues; a monitor pops and compares
// them whenever the DUT strobes dst_we or done. A driver process produces a
// cen on every other clk and answers busrq_n with busak_n, with an optional
// 5-cen bus pause at k=100.
// ---------------------------------------------------------------------------
module tb_jtpopeye_dma_sched;
   localparam int AW  = 10;
   localparam int LEN = 384;

   logic          clk = 1'b0;
   logic          rst, cen, VB, dma_en, busak_n;
   logic          busrq_n, dst_we, busy, done;
   logic [AW-1:0] src_addr, dst_addr;
   logic [7:0]    src_data, dst_data;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   logic          err;
`endif

   always #5 clk = ~clk;

   jtpopeye_dma_sched #(.AW(AW), .LEN(LEN)) dut (
      .clk(clk), .rst(rst), .cen(cen), .VB(VB), .dma_en(dma_en),
      .busrq_n(busrq_n), .busak_n(busak_n),
      .src_addr(src_addr), .src_data(src_data),
      .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
      .busy(busy), .done(done)
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      , .err(err)
`endif
   );

   // source RAM, one cen of read latency
   logic [7:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = 8'((i * 37) ^ (i >> 3) ^ 8'h5A);
   always @(posedge clk) if (cen) src_data <= mem[src_addr];

   typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
   wr_t exp_q[$];
   bit  done_q[$];
   int  errors = 0, checks = 0;
   int  wr_cnt = 0, done_cnt = 0;

   // driver controls
   bit ack_on = 1'b1, gap_mode = 1'b0, gap_done = 1'b0;
   int gap = 0, rq_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // cen and bus-acknowledge driver
   initial begin
      cen = 1'b0; busak_n = 1'b1;
      forever begin
         @(negedge clk);
         if (busrq_n) rq_cnt = 0;
         if (gap_mode && !gap_done && !busrq_n && dst_addr == 10'd99) begin
            gap = 5; gap_done = 1'b1;
         end
         cen = ~cen;
         if (cen) begin
            if (gap > 0) begin busak_n = 1'b1; gap--; end
            else busak_n = !(ack_on && !busrq_n && rq_cnt >= 2);
            if (!busrq_n && rq_cnt < 2) rq_cnt++;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      wr_t e;
      forever begin
         @(negedge clk); #1;
         if (dst_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write addr=%0d required no write", dst_addr);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(dst_addr), 32'(e.a));
               check("wr_data", 32'(dst_data), 32'(e.d));
               check("wr_busrq_n", 32'(busrq_n), 32'd0);
            end
         end
         if (cen && busak_n && !busrq_n) check("no_we_without_ack", 32'(dst_we), 32'd0);
         if (done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               void'(done_q.pop_front());
               check("done_busrq_n", 32'(busrq_n), 32'd1);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_frame(input int n, input bit with_done);
      for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(i), d: mem[i]});
      if (with_done) done_q.push_back(1'b1);
   endtask

   task automatic vb_pulse();
      VB = 1'b1; cyc(8); VB = 1'b0; cyc(4);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int t = 0;
      while (busy && t < budget) begin cyc(1); t++; end
      if (busy) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", nm, budget);
      end
   endtask

   task automatic wait_k(input logic [AW-1:0] a, input int budget);
      int t = 0;
      while (!(!busrq_n && busy && dst_addr == a) && t < budget) begin cyc(1); t++; end
      if (t >= budget) begin
         checks++; errors++;
         $display("FAIL wait_k_timeout actual=not reached required=dst_addr %0d", a);
      end
   endtask

   task automatic frame_end_checks(input string nm, input int w0, input int d0, input int nw, input int nd);
      check({nm, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
      check({nm, "_dones"}, 32'(done_cnt - d0), 32'(nd));
      check({nm, "_exp_q_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int w0, d0, mx;
      rst = 1'b1; VB = 1'b1; dma_en = 1'b1;
      cyc(4); #1;
      check("rst_busrq_n", 32'(busrq_n), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dst_we", 32'(dst_we), 32'd0);
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      check("rst_err", 32'(err), 32'd0);
`endif
      // VB already high when reset releases: not an edge
      rst = 1'b0; cyc(20); #1;
      check("vb_high_at_release_busy", 32'(busy), 32'd0);
      VB = 1'b0; cyc(6);

      // plain transfer
      w0 = wr_cnt; d0 = done_cnt;
      push_frame(LEN, 1'b1);
      vb_pulse(); #1;
      check("start_busy", 32'(busy), 32'd1);
      wait_idle("xfer1", 4000); cyc(4);
      frame_end_checks("xfer1", w0, d0, LEN, 1);

      // dma_en low at the VB edge: nothing happens for the frame
      dma_en = 1'b0; mx = 0;
      VB = 1'b1;
      for (int i = 0; i < 60; i++) begin cyc(1); #1; if (busy || !busrq_n) mx = 1; end
      VB = 1'b0; cyc(4);
      check("dma_en0_no_activity", 32'(mx), 32'd0);
      dma_en = 1'b1;

      // 5-cen bus pause at k=100
      w0 = wr_cnt; d0 = done_cnt;
      gap_mode = 1'b1; gap_done = 1'b0;
      push_frame(LEN, 1'b1);
      vb_pulse();
      wait_idle("gap", 4000); cyc(4);
      gap_mode = 1'b0;
      check("gap_taken", 32'(gap_done), 32'd1);
      frame_end_checks("gap", w0, d0, LEN, 1);

      // dma_en dropped and VB edges again during XFER: one transfer only
      w0 = wr_cnt; d0 = done_cnt;
      push_frame(LEN, 1'b1);
      vb_pulse();
      wait_k(10'd50, 400);
      dma_en = 1'b0; cyc(2); dma_en = 1'b1;
      vb_pulse();
      wait_idle("revb", 4000);
      cyc(60); #1;
      check("revb_no_second", 32'(busy), 32'd0);
      frame_end_checks("revb", w0, d0, LEN, 1);

      // reset at k=200: bytes 0..198 written, then the bus is released
      w0 = wr_cnt; d0 = done_cnt;
      push_frame(199, 1'b0);
      vb_pulse();
      wait_k(10'd199, 1000);
      rst = 1'b1; cyc(1); #1;
      check("midrst_busrq_n", 32'(busrq_n), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0; cyc(200);
      frame_end_checks("midrst", w0, d0, 199, 0);

      // no acknowledge for a long time
      w0 = wr_cnt; d0 = done_cnt;
      ack_on = 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      vb_pulse();
      wait_idle("to", 300); cyc(2); #1;
      check("to_busrq_n", 32'(busrq_n), 32'd1);
      check("to_err", 32'(err), 32'd1);
      frame_end_checks("to", w0, d0, 0, 0);
      ack_on = 1'b1;
      w0 = wr_cnt; d0 = done_cnt;
      push_frame(LEN, 1'b1);
      vb_pulse();
      wait_idle("after_to", 4000); cyc(4); #1;
      check("err_sticky", 32'(err), 32'd1);
      frame_end_checks("after_to", w0, d0, LEN, 1);
`else
      push_frame(LEN, 1'b1);
      vb_pulse();
      cyc(300); #1;
      check("noack_still_req_busy", 32'(busy), 32'd1);
      check("noack_still_req_busrq_n", 32'(busrq_n), 32'd0);
      ack_on = 1'b1;
      wait_idle("late_ack", 4000); cyc(4);
      frame_end_checks("late_ack", w0, d0, LEN, 1);
`endif

      check("done_q_left", 32'(done_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
